// File: rtl/mux_scan.sv
// Registered N-way channel multiplexer with manual select and auto-scan modes.
// All outputs update on the rising edge; hold freezes outputs and the scan pointer.
module mux_scan #(
  parameter int unsigned N  = 5,
  parameter int unsigned W  = 1,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  d,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            adv,
  input  logic            hold,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            y_valid,
  output logic            wrap
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          pend_q, pend_d;

  logic [SW-1:0] idx;
  logic [W-1:0]  dec_y;
  logic          dec_v;

  // Next-state: decode idx over legal channels only, so out-of-range values read as 0/invalid.
  // A wrap is remembered in pend_q and pulsed when ch first presents channel 0 again.
  always_comb begin
    idx     = mode ? ptr_q : sel;
    dec_y   = '0;
    dec_v   = 1'b0;
    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    wrap_d  = 1'b0;

    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) begin
        dec_y = d[k*W +: W];
        dec_v = 1'b1;
      end
    end

    if (!hold) begin
      y_d     = dec_y;
      ch_d    = idx;
      valid_d = dec_v;
      if (mode && pend_q) begin
        wrap_d = 1'b1;
        pend_d = 1'b0;
      end
      if (mode && adv) begin
        if (ptr_q == LAST) begin
          ptr_d  = '0;
          pend_d = 1'b1;
        end else begin
          ptr_d = ptr_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  assign y       = y_q;
  assign ch      = ch_q;
  assign y_valid = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan: a 5x4 instance and a 16x32 instance.
module tb_mux_scan;

  logic clk;
  logic rst_n;

  logic [19:0] d_a;
  logic [2:0]  sel_a;
  logic        mode_a, adv_a, hold_a;
  logic [3:0]  y_a;
  logic [2:0]  ch_a;
  logic        v_a, wrap_a;

  logic [511:0] d_b;
  logic [3:0]   sel_b;
  logic         mode_b, adv_b, hold_b;
  logic [31:0]  y_b;
  logic [3:0]   ch_b;
  logic         v_b, wrap_b;

  int n_cmp;
  int n_err;

  mux_scan #(.N(5), .W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .sel(sel_a), .mode(mode_a),
    .adv(adv_a), .hold(hold_a), .y(y_a), .ch(ch_a), .y_valid(v_a), .wrap(wrap_a)
  );

  mux_scan #(.N(16), .W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .sel(sel_b), .mode(mode_b),
    .adv(adv_b), .hold(hold_b), .y(y_b), .ch(ch_b), .y_valid(v_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bval(input int k);
    return 32'h1357_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  initial begin
    logic [3:0] exp_y[8];
    logic       exp_v[8];
    logic [2:0] exp_ch[7];
    logic       exp_wr[7];
    int         wraps;

    exp_y  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0};
    exp_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_ch = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    exp_wr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp = 0;
    n_err = 0;

    rst_n  = 1'b0;
    d_a    = 20'h54321;
    sel_a  = 3'd0;
    mode_a = 1'b0;
    adv_a  = 1'b0;
    hold_a = 1'b0;
    for (int k = 0; k < 16; k++) d_b[k*32 +: 32] = bval(k);
    sel_b  = 4'd0;
    mode_b = 1'b0;
    adv_b  = 1'b0;
    hold_b = 1'b0;

    // Reset state
    #3;
    chk("rst_y", 32'(y_a), 32'h0);
    chk("rst_ch", 32'(ch_a), 32'h0);
    chk("rst_valid", 32'(v_a), 32'h0);
    chk("rst_wrap", 32'(wrap_a), 32'h0);
    chk("rst_b_y", y_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select sweep including out-of-range sel
    for (int s = 0; s < 8; s++) begin
      sel_a = 3'(s);
      step();
      chk($sformatf("man_y%0d", s), 32'(y_a), 32'(exp_y[s]));
      chk($sformatf("man_v%0d", s), 32'(v_a), 32'(exp_v[s]));
      chk($sformatf("man_ch%0d", s), 32'(ch_a), 32'(s));
    end

    // Auto-scan from channel 0 with wrap
    mode_a = 1'b1;
    adv_a  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("scan_ch%0d", i), 32'(ch_a), 32'(exp_ch[i]));
      chk($sformatf("scan_wrap%0d", i), 32'(wrap_a), 32'(exp_wr[i]));
      chk($sformatf("scan_y%0d", i), 32'(y_a), 32'(exp_ch[i]) + 32'd1);
    end

    // Hold mid-scan with adv high and d changing
    step();
    step();
    chk("pre_hold_ch", 32'(ch_a), 32'd3);
    hold_a = 1'b1;
    d_a    = 20'hABCDE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_y%0d", i), 32'(y_a), 32'h4);
      chk($sformatf("hold_ch%0d", i), 32'(ch_a), 32'd3);
      chk($sformatf("hold_v%0d", i), 32'(v_a), 32'h1);
      chk($sformatf("hold_wrap%0d", i), 32'(wrap_a), 32'h0);
    end
    hold_a = 1'b0;
    step();
    chk("resume_ch4", 32'(ch_a), 32'd4);
    chk("resume_y4", 32'(y_a), 32'hA);
    chk("resume_wrap4", 32'(wrap_a), 32'h0);
    step();
    chk("resume_ch0", 32'(ch_a), 32'd0);
    chk("resume_y0", 32'(y_a), 32'hE);
    chk("resume_wrap0", 32'(wrap_a), 32'h1);
    d_a = 20'h54321;

    // Mode switches: ptr retained across manual excursion
    step();
    chk("sw_pre_ch", 32'(ch_a), 32'd1);
    mode_a = 1'b0;
    sel_a  = 3'd4;
    step();
    chk("sw_man_y", 32'(y_a), 32'h5);
    chk("sw_man_ch", 32'(ch_a), 32'd4);
    chk("sw_man_wrap", 32'(wrap_a), 32'h0);
    mode_a = 1'b1;
    adv_a  = 1'b0;
    step();
    chk("sw_auto_y", 32'(y_a), 32'h3);
    chk("sw_auto_ch", 32'(ch_a), 32'd2);

    // Hold coinciding with the wrap condition delays the wrap
    adv_a = 1'b1;
    step();
    step();
    chk("hw_pre_ch", 32'(ch_a), 32'd3);
    hold_a = 1'b1;
    step();
    chk("hw_hold_wrap0", 32'(wrap_a), 32'h0);
    step();
    chk("hw_hold_wrap1", 32'(wrap_a), 32'h0);
    chk("hw_hold_ch", 32'(ch_a), 32'd3);
    hold_a = 1'b0;
    step();
    chk("hw_rel_ch", 32'(ch_a), 32'd4);
    chk("hw_rel_wrap", 32'(wrap_a), 32'h0);
    step();
    chk("hw_wrap_ch", 32'(ch_a), 32'd0);
    chk("hw_wrap", 32'(wrap_a), 32'h1);

    // Asynchronous reset between edges at ptr=4
    step();
    step();
    step();
    chk("ar_pre_ch", 32'(ch_a), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_y", 32'(y_a), 32'h0);
    chk("ar_ch", 32'(ch_a), 32'h0);
    chk("ar_valid", 32'(v_a), 32'h0);
    chk("ar_wrap", 32'(wrap_a), 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_post_ch0", 32'(ch_a), 32'd0);
    chk("ar_post_y0", 32'(y_a), 32'h1);
    step();
    chk("ar_post_ch1", 32'(ch_a), 32'd1);

    // Wide instance: full manual sweep
    for (int s = 0; s < 16; s++) begin
      sel_b = 4'(s);
      step();
      chk($sformatf("b_man_y%0d", s), y_b, bval(s));
      chk($sformatf("b_man_v%0d", s), 32'(v_b), 32'h1);
      chk($sformatf("b_man_ch%0d", s), 32'(ch_b), 32'(s));
    end

    // Wide instance: 33 advances from channel 0 give exactly two wraps
    mode_b = 1'b1;
    adv_b  = 1'b1;
    wraps  = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      chk($sformatf("b_scan_ch%0d", i), 32'(ch_b), 32'(i % 16));
      chk($sformatf("b_scan_y%0d", i), y_b, bval(i % 16));
      chk($sformatf("b_scan_v%0d", i), 32'(v_b), 32'h1);
      chk($sformatf("b_scan_wrap%0d", i), 32'(wrap_b), 32'((i > 0) && (i % 16 == 0)));
      if (wrap_b) wraps++;
    end
    chk("b_wrap_count", 32'(wraps), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
